// File: rtl/mano_seq_alu.sv
// Multi-cycle Basic Computer ALU: single-cycle AC/DR/INPR/E ops, multi-step
// circulate through E, serial shift-add multiply, with start/busy/done handshake.
module mano_seq_alu #(
  parameter int WIDTH  = 16,
  parameter int INPR_W = 8,
  parameter int SH_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [WIDTH-1:0]  ac,
  input  logic [WIDTH-1:0]  dr,
  input  logic [INPR_W-1:0] inpr,
  input  logic              ei,
  input  logic [SH_W-1:0]   shamt,
  output logic [WIDTH-1:0]  res,
  output logic              eo,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_LDDR = 4'd3;
  localparam logic [3:0] OP_LDIN = 4'd4;
  localparam logic [3:0] OP_CMA  = 4'd5;
  localparam logic [3:0] OP_CIR  = 4'd6;
  localparam logic [3:0] OP_CIL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;

  // Counter must hold either the circulate count or WIDTH-1 multiply steps.
  localparam int CNT_W = ((SH_W > $clog2(WIDTH)) ? SH_W : $clog2(WIDTH)) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state, state_nx;
  logic [3:0]           op_q;
  logic [WIDTH:0]       ring;      // {E, AC} circulate ring
  logic [WIDTH:0]       ring_nx;
  logic [2*WIDTH-1:0]   acc;       // partial product
  logic [2*WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0]   mcand;     // multiplicand, pre-shifted to current bit weight
  logic [WIDTH-1:0]     mplier;    // remaining multiplier bits, LSB is next
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic                 accept;
  logic                 multi;
  logic [WIDTH-1:0]     one_res;
  logic                 one_eo;
  logic                 one_err;

  // One rotate-right step of the {E,AC} ring: E'=AC[0], AC'={E,AC[W-1:1]}.
  function automatic logic [WIDTH:0] cir_step(input logic [WIDTH:0] r);
    return {r[0], r[WIDTH:1]};
  endfunction

  // One rotate-left step of the {E,AC} ring: E'=AC[W-1], AC'={AC[W-2:0],E}.
  function automatic logic [WIDTH:0] cil_step(input logic [WIDTH:0] r);
    return {r[WIDTH-1:0], r[WIDTH]};
  endfunction

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(1));
  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);

  // Accept-edge result: full result for single-cycle ops, first step for CIR/CIL.
  always_comb begin
    one_res = res;
    one_eo  = eo;
    one_err = 1'b0;
    multi   = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_AND:  begin one_res = ac & dr; one_eo = 1'b0; end
      OP_ADD:  {one_eo, one_res} = {1'b0, ac} + {1'b0, dr};
      OP_LDDR: begin one_res = dr; one_eo = 1'b0; end
      OP_LDIN: begin one_res = WIDTH'(inpr); one_eo = 1'b0; end
      OP_CMA:  begin one_res = ~ac; one_eo = 1'b0; end
      OP_CIR: begin
        {one_eo, one_res} = (shamt == '0) ? {ei, ac} : cir_step({ei, ac});
        multi = (shamt > SH_W'(1));
      end
      OP_CIL: begin
        {one_eo, one_res} = (shamt == '0) ? {ei, ac} : cil_step({ei, ac});
        multi = (shamt > SH_W'(1));
      end
      OP_MUL: begin
        // Only used directly when WIDTH==1, where the product is a single AND.
        one_res = ac & dr;
        one_eo  = 1'b0;
        multi   = (WIDTH > 1);
      end
      OP_INC:  {one_eo, one_res} = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
      default: one_err = 1'b1;
    endcase
  end

  // Iteration step for the op in flight.
  always_comb begin
    ring_nx = (op_q == OP_CIL) ? cil_step(ring) : cir_step(ring);
    acc_nx  = acc + (mplier[0] ? mcand : '0);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = multi ? RUN : FINISH;
      RUN:     if (last) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      eo  <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      op_q   <= opcode;
      ring   <= {one_eo, one_res};
      acc    <= dr[0] ? {{WIDTH{1'b0}}, ac} : '0;
      mcand  <= {{WIDTH{1'b0}}, ac} << 1;
      mplier <= dr >> 1;
      cnt    <= (opcode == OP_MUL) ? CNT_W'(WIDTH - 1) : (CNT_W'(shamt) - CNT_W'(1));
      if (!multi) begin
        res <= one_res;
        eo  <= one_eo;
        err <= one_err;
      end
    end else if (state == RUN) begin
      ring   <= ring_nx;
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (last) begin
        if (op_q == OP_MUL) begin
          res <= acc_nx[WIDTH-1:0];
          eo  <= |acc_nx[2*WIDTH-1:WIDTH];
        end else begin
          res <= ring_nx[WIDTH-1:0];
          eo  <= ring_nx[WIDTH];
        end
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mano_seq_alu.sv
// Directed testbench for mano_seq_alu (WIDTH=16, INPR_W=8, SH_W=4).
module tb_mano_seq_alu;

  localparam int WIDTH  = 16;
  localparam int INPR_W = 8;
  localparam int SH_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        opcode;
  logic [WIDTH-1:0]  ac;
  logic [WIDTH-1:0]  dr;
  logic [INPR_W-1:0] inpr;
  logic              ei;
  logic [SH_W-1:0]   shamt;
  logic [WIDTH-1:0]  res;
  logic              eo;
  logic              busy;
  logic              done;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  mano_seq_alu #(.WIDTH(WIDTH), .INPR_W(INPR_W), .SH_W(SH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ac(ac), .dr(dr),
    .inpr(inpr), .ei(ei), .shamt(shamt), .res(res), .eo(eo), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Hard stop if anything hangs.
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Issue one op; returns edges from accept to done (accept edge = 1), -1 on timeout.
  // Operands are scrambled right after the accept edge to prove they were captured.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d,
                        input logic [7:0] inp, input logic e, input logic [3:0] sh,
                        output int lat);
    @(negedge clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    opcode = op; ac = a; dr = d; inpr = inp; ei = e; shamt = sh; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0; opcode = 4'hF; ac = ~a; dr = ~d; inpr = ~inp; ei = ~e; shamt = ~sh;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; opcode = 4'd2; ac = 16'hFFFF; dr = 16'h0001;
    inpr = '0; ei = 1'b0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({res, eo, busy, done, err} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_state: got res=%h eo=%b busy=%b done=%b err=%b want all 0",
               res, eo, busy, done, err);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  op [9] = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd9, 4'd9, 4'd2, 4'd0};
    logic [15:0] a  [9] = '{16'hFFFF, 16'hF0F0, 16'h1111, 16'h2222, 16'h1234,
                            16'h00FF, 16'hFFFF, 16'hFFFF, 16'h5555};
    logic [15:0] d  [9] = '{16'h0001, 16'h3C3C, 16'hBEEF, 16'h3333, 16'h4444,
                            16'h7777, 16'h0000, 16'hFFFF, 16'h6666};
    logic [7:0]  ip [9] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
    logic        e  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] xr [9] = '{16'h0000, 16'h3030, 16'hBEEF, 16'h00A5, 16'hEDCB,
                            16'h0100, 16'h0000, 16'hFFFE, 16'hFFFE};
    logic        xe [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(op[i], a[i], d[i], ip[i], e[i], 4'd3, lat);
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL single_lat[%0d]: got %0d want 1", i, lat);
      end
      vectors++;
      if ({res, eo, err, busy} !== {xr[i], xe[i], 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL single_res[%0d]: got res=%h eo=%b err=%b busy=%b want res=%h eo=%b err=0 busy=1",
                 i, res, eo, err, busy, xr[i], xe[i]);
      end
      @(posedge clk); #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL single_idle[%0d]: got busy=%b done=%b want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_circulate();
    logic [3:0]  op [8] = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd7, 4'd6, 4'd6, 4'd7};
    logic [15:0] a  [8] = '{16'h0003, 16'h1234, 16'h8000, 16'hABCD, 16'h8001,
                            16'h0001, 16'hABCD, 16'h1234};
    logic        e  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  sh [8] = '{4'd1, 4'd4, 4'd1, 4'd0, 4'd3, 4'd15, 4'd0, 4'd4};
    int          xl [8] = '{1, 4, 1, 1, 3, 15, 1, 4};
    logic [15:0] xr [8] = '{16'h0001, 16'h9123, 16'h0000, 16'hABCD, 16'h000A,
                            16'h0004, 16'hABCD, 16'h2348};
    logic        xe [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(op[i], a[i], 16'h5A5A, 8'h00, e[i], sh[i], lat);
      vectors++;
      if (lat !== xl[i]) begin
        miscompares++;
        $display("FAIL circ_lat[%0d]: got %0d want %0d", i, lat, xl[i]);
      end
      vectors++;
      if ({res, eo, err} !== {xr[i], xe[i], 1'b0}) begin
        miscompares++;
        $display("FAIL circ_res[%0d]: got res=%h eo=%b err=%b want res=%h eo=%b err=0",
                 i, res, eo, err, xr[i], xe[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [15:0] a  [4] = '{16'h0003, 16'hFFFF, 16'h00FF, 16'h0100};
    logic [15:0] d  [4] = '{16'h0005, 16'hFFFF, 16'h0101, 16'h0101};
    logic [15:0] xr [4] = '{16'h000F, 16'h0001, 16'hFFFF, 16'h0100};
    logic        xe [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(4'd8, a[i], d[i], 8'h00, 1'b1, 4'd2, lat);
      vectors++;
      if (lat !== 16) begin
        miscompares++;
        $display("FAIL mul_lat[%0d]: got %0d want 16", i, lat);
      end
      vectors++;
      if ({res, eo, err} !== {xr[i], xe[i], 1'b0}) begin
        miscompares++;
        $display("FAIL mul_res[%0d]: got res=%h eo=%b err=%b want res=%h eo=%b err=0",
                 i, res, eo, err, xr[i], xe[i]);
      end
    end
  endtask

  // Runs right after test_mul, so res=0100 eo=1 must be held.
  task automatic test_illegal();
    int lat;
    run_op(4'hC, 16'h1234, 16'h5678, 8'h9A, 1'b0, 4'd1, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL illegal_c_lat: got %0d want 1", lat);
    end
    vectors++;
    if ({res, eo, err} !== {16'h0100, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_c: got res=%h eo=%b err=%b want res=0100 eo=1 err=1", res, eo, err);
    end
    run_op(4'hF, 16'h1234, 16'h5678, 8'h9A, 1'b0, 4'd1, lat);
    vectors++;
    if ({lat == 1, res, eo, err} !== {1'b1, 16'h0100, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_f: got lat=%0d res=%h eo=%b err=%b want lat=1 res=0100 eo=1 err=1",
               lat, res, eo, err);
    end
    run_op(4'd3, 16'h0000, 16'h0007, 8'h00, 1'b1, 4'd0, lat);
    vectors++;
    if ({res, eo, err} !== {16'h0007, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL illegal_clear: got res=%h eo=%b err=%b want res=0007 eo=0 err=0", res, eo, err);
    end
  endtask

  // start held high through a MUL: the AND behind it must wait for IDLE.
  task automatic test_back_to_back();
    int dcount = 0;
    int first  = -1;
    int second = -1;
    @(negedge clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    opcode = 4'd8; ac = 16'h0003; dr = 16'h0005; ei = 1'b0; shamt = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd1; ac = 16'hF0F0; dr = 16'h3C3C;
    for (int i = 1; i <= 24; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (done) begin
        dcount++;
        if (first < 0) begin
          first = i;
          vectors++;
          if ({res, eo} !== {16'h000F, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_mul_res: got res=%h eo=%b want res=000F eo=0", res, eo);
          end
        end else if (second < 0) begin
          second = i;
          start = 1'b0;
        end
      end
    end
    vectors++;
    if ({first, second, dcount} !== {32'd16, 32'd18, 32'd2}) begin
      miscompares++;
      $display("FAIL b2b_done_pulses: got first=%0d second=%0d count=%0d want 16 18 2",
               first, second, dcount);
    end
    vectors++;
    if ({res, eo, err} !== {16'h3030, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_and_res: got res=%h eo=%b err=%b want res=3030 eo=0 err=0", res, eo, err);
    end
  endtask

  // rst at the 5th edge of a MUL, with a start presented alongside it.
  task automatic test_reset_midrun();
    int dcount = 0;
    @(negedge clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    opcode = 4'd8; ac = 16'h0003; dr = 16'h0005; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL midrun_busy: got busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk); rst = 1'b1; start = 1'b1; opcode = 4'd2;
    @(posedge clk); #1;
    vectors++;
    if ({res, eo, busy, done, err} !== 20'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: got res=%h eo=%b busy=%b done=%b err=%b want all 0",
               res, eo, busy, done, err);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    vectors++;
    if (dcount !== 0) begin
      miscompares++;
      $display("FAIL midrun_no_done: got %0d busy/done cycles want 0", dcount);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_circulate();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mano_seq_alu.md
Name: mano_seq_alu

Overview:
- Parametrised, multi-cycle successor to the Basic Computer ALU.
- Covers all existing AC/DR/INPR/E operations at generic WIDTH.
- Adds a start/busy/done handshake, multi-step circulate through E, a serial shift-add multiply, an increment, and an illegal-opcode flag.
- Sits between the control unit and the AC/E registers. The control unit pulses start, then writes res/eo into AC/E on done.

Parameters:
- WIDTH, 16, data width of ac, dr and res.
- INPR_W, 8, width of inpr; zero-extended to WIDTH (INPR_W <= WIDTH).
- SH_W, 4, width of shamt; max circulate count is 2^SH_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- opcode  input  4  operation select (below)
- ac  input  WIDTH  accumulator operand
- dr  input  WIDTH  data-register operand
- inpr  input  INPR_W  input-register operand
- ei  input  1  current E flag
- shamt  input  SH_W  circulate step count (opcodes 6/7 only)
- res  output  WIDTH  registered result
- eo  output  1  registered new E value
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- err  output  1  registered illegal-opcode flag

Behaviour:
- Reset (rst=1 at a rising edge): res=0, eo=0, busy=0, done=0, err=0, state=IDLE. Any in-flight operation is aborted with no done pulse. Reset has priority over start.
- Capture: start=1 with busy=0 at edge k latches opcode, ac, dr, ei, inpr and shamt. Operand changes after edge k are ignored. start while busy=1 is ignored, not queued.
- States:
  - IDLE: holds res/eo/err.
  - RUN: iterative ops; counter loaded at accept, decremented each edge.
  - FINISH: internal; done=1 for exactly one cycle, then IDLE.
  - busy=1 in every state except IDLE. start is therefore ignored during the done cycle and accepted from the following cycle.
- Latency L (done is high in cycle k+L, i.e. after L edges counting the accepting edge):
  - Single-cycle ops: L=1.
  - CIR/CIL: L=max(shamt,1).
  - MUL: L=WIDTH.
- res, eo and err update only on the edge that raises done, and hold until the next completion. err updates on every completion: 1 for an illegal opcode, else 0.
- Opcodes:
  - 0 NOP: res, eo hold; done pulses; err=0.
  - 1 AND: res=ac&dr; eo=0.
  - 2 ADD: {eo,res}=ac+dr (WIDTH+1-bit unsigned sum).
  - 3 LDDR: res=dr; eo=0.
  - 4 LDIN: res=zero-extended inpr; eo=0.
  - 5 CMA: res=~ac; eo=0.
  - 6 CIR: shamt steps on the (WIDTH+1)-bit ring {E,AC}. Per step: E'=AC[0], AC'={E,AC[WIDTH-1:1]}.
  - 7 CIL: shamt steps. Per step: E'=AC[WIDTH-1], AC'={AC[WIDTH-2:0],E}.
  - CIR/CIL with shamt=0: res=ac, eo=ei, L=1.
  - 8 MUL: unsigned ac*dr by serial shift-add, one multiplier bit per cycle. res = low WIDTH bits; eo=1 iff any high WIDTH bits are nonzero (overflow).
  - 9 INC: {eo,res}=ac+1.
  - 10-15 illegal: res/eo hold, err=1, L=1.
- Outputs carry no X/Z for any opcode; there is no tri-state default.
- rst asserted mid-RUN: the next edge returns to IDLE with all outputs zero. A start presented with rst is dropped.

Test Plan:
- ADD, WIDTH=16: ac=FFFF, dr=0001, start at edge k -> done at k+1, res=0000, eo=1, busy was high for one cycle. Then AND ac=F0F0, dr=3C3C -> res=3030, eo=0.
- CIR: ac=0003, ei=0, shamt=1 -> res=0001, eo=1, L=1. Then ac=1234, ei=1, shamt=4 -> done after 4 edges, res=9123, eo=0.
- CIL / zero count: ac=8000, ei=0, shamt=1 -> res=0000, eo=1. shamt=0, ac=ABCD, ei=1 -> res=ABCD, eo=1, L=1.
- MUL: ac=0003, dr=0005 -> done exactly 16 edges after accept, res=000F, eo=0. ac=0100, dr=0101 -> res=0100, eo=1.
- Handshake: start held high during a MUL with new opcode=1 -> ignored, res stays at the MUL result. After done deasserts, a new start is accepted; done never pulses twice for one accept.
- Reset/illegal: rst at cycle 5 of a MUL -> next cycle res=0, eo=0, busy=0, no done. opcode=C -> done at L=1, err=1, res unchanged.
